lmg_seq: RTL and testbench
==========================

Name: lmg_seq

Overview:
- Sequencer that owns one LMG legal-move-generator instance and sits between LMG and the search engine.
- On `start` it latches the board state and castle/en-passant flags, then restarts LMG and waits for `done`.
- It then drains LMG's 160-bit move FIFO and unpacks each word into up to eight 19-bit moves.
- Valid moves go out one per handshake; invalid slots are dropped. The total move count is reported at the end.

Parameters:
- RST_CYCLES, 2: number of cycles `lmg_reset` is held high before LMG is released.
- TIMEOUT, 4096: maximum cycles to wait for `lmg_done` before flagging an error.
- RD_LAT, 1: cycles from the `lmg_rden` pulse until `lmg_fifo_out` holds the read word.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  return to IDLE from any state
- bstate_in  in  256  board state to evaluate
- lcas_in  in  1  left-castle allowed
- rcas_in  in  1  right-castle allowed
- enp_in  in  8  en-passant file flags
- lmg_reset  out  1  active-high restart to LMG
- lmg_bstate  out  256  latched board state
- lmg_lcas  out  1  latched `lcas_in`
- lmg_rcas  out  1  latched `rcas_in`
- lmg_enp  out  8  latched `enp_in`
- lmg_done  in  1  LMG generation complete
- lmg_fifo_empty  in  1  LMG FIFO empty
- lmg_fifo_out  in  160  packed word; slot k (k=1..8) at [151-19(k-1) -: 19]; bits [159:152] ignored
- lmg_rden  out  1  FIFO read strobe, one cycle per word
- mv_valid  out  1  move available
- mv_data  out  19  move: [18] invalid flag (always 0 when `mv_valid`), [11:6] from square, [5:0] to square
- mv_ready  in  1  consumer accepts the move
- busy  out  1  high in every state except IDLE
- gen_done  out  1  one-cycle pulse at end of a run
- mv_count  out  8  valid moves emitted in the last run; saturates at 255
- timeout_err  out  1  sticky error; cleared on the next accepted `start`

Behaviour:
- Reset values: all outputs 0, except `lmg_reset` = 1 (LMG held in reset). State = IDLE.
- IDLE
  - `start` = 1: latch `bstate_in`, `lcas_in`, `rcas_in`, `enp_in` into the `lmg_*` outputs; clear `mv_count` and `timeout_err`; go to RST.
- RST
  - `lmg_reset` = 1 for RST_CYCLES cycles, then deasserted; go to WAIT.
- WAIT
  - Counter runs while waiting for `lmg_done`.
  - `lmg_done` = 1: go to READ.
  - Counter reaches TIMEOUT: set `timeout_err`, pulse `gen_done`, go to IDLE.
- READ
  - `lmg_fifo_empty` = 1: go to FIN.
  - Otherwise pulse `lmg_rden` for exactly 1 cycle; go to CAP.
- CAP
  - Wait RD_LAT cycles after the rden cycle, latch `lmg_fifo_out` into the unpack register, set slot pointer = 1; go to EMIT.
- EMIT, one slot examined per cycle:
  - Slot bit[18] = 1: skip it, advance the pointer, no output.
  - Slot valid: drive `mv_valid` = 1 with `mv_data` = slot; hold both stable until a cycle with `mv_ready` = 1. On that accept, increment `mv_count` (saturating at 255) and advance the pointer.
  - After slot 8 is consumed: go to READ.
  - `mv_valid` may rise without waiting for `mv_ready`. It never drops without an accept, except on `abort`/`reset`.
- FIN
  - Pulse `gen_done` for 1 cycle; `mv_count` holds its value until the next `start`; go to IDLE.
- `abort` (any state): go to IDLE next cycle; `mv_valid` = 0, `lmg_rden` = 0, `lmg_reset` = 1; no `gen_done` pulse; `mv_count` keeps its partial value.
- `start` while busy: ignored. `start` and `abort` in the same cycle: `abort` wins.
- Async reset mid-run: immediate return to reset values; a partially read FIFO word is discarded. LMG is restarted on the next run.
- LMG done but FIFO already empty: READ goes straight to FIN; `mv_count` = 0.
- All eight slots of a word invalid: 8 EMIT cycles, then READ; no output.
- Slot order is always 1→8 (MSB-first), matching the bench print order.
- `lmg_done` dropping after WAIT is ignored.

Decomposition:
- Shared package `lmg_pkg`:
  - MOVE_W=19, WORD_W=160, SLOTS=8, BSTATE_W=256
  - Field offsets INV_BIT=18, FROM_HI/LO=11/6, TO_HI/LO=5/0
  - State enum
  - Function `slot(word,k)` returning the 19-bit slot.
- One natural sub-module, `lmg_unpack`: holds the 160-bit register, slot pointer and valid/ready output stage, and reports `word_consumed`. The FSM stays in `lmg_seq`.

Test Plan:
- Start with `lmg_done` after 10 cycles and one FIFO word whose slots 1–3 are from 014→024, 014→034, 001→022 (octal) and slots 4–8 have bit18=1; `mv_ready` tied 1 → 3 moves out in slot order, `mv_count`=3, one `gen_done` pulse, 1 `lmg_rden` pulse.
- Two FIFO words, 8 + 4 valid moves; `mv_ready` toggling 1-0-1 → `mv_data` stable while `mv_ready`=0, 12 moves out, `mv_count`=12, 2 rden pulses.
- `lmg_done` with `lmg_fifo_empty`=1 → 0 moves, `mv_count`=0, `gen_done` within 2 cycles.
- `lmg_done` never asserts, TIMEOUT=64 → `timeout_err`=1 and `gen_done` at cycle 64 of WAIT; a new `start` clears `timeout_err`.
- `abort` during EMIT after 2 accepts → IDLE next cycle, `mv_valid`=0, `lmg_reset`=1, no `gen_done`, `mv_count`=2.
- Assert `reset`=0 asynchronously mid-EMIT → all outputs at reset values with no clock edge; `start` = 1 while busy → no effect.

Source files
------------

// File: rtl/lmg_pkg.sv
// lmg_pkg: shared widths, move field offsets, sequencer states and slot extraction
// Used by lmg_seq and lmg_unpack; no ports.
package lmg_pkg;
    localparam int MOVE_W   = 19;
    localparam int WORD_W   = 160;
    localparam int SLOTS    = 8;
    localparam int BSTATE_W = 256;
    localparam int INV_BIT  = 18;
    localparam int FROM_HI  = 11;
    localparam int FROM_LO  = 6;
    localparam int TO_HI    = 5;
    localparam int TO_LO    = 0;
    // Slot 1 starts just below the unused top byte of the FIFO word.
    localparam int SLOT_TOP = SLOTS * MOVE_W - 1;

    typedef enum logic [2:0] {IDLE, RST, WAIT, READ, CAP, EMIT, FIN} lmgState;

    // Slot k (1..8) of a packed FIFO word, MSB-first.
    function automatic logic [MOVE_W-1:0] slot(input logic [WORD_W-1:0] word, input int k);
        return word[SLOT_TOP - MOVE_W * (k - 1) -: MOVE_W];
    endfunction
endpackage

// File: rtl/lmg_unpack.sv
// lmg_unpack: holds one FIFO word and presents its valid slots one per handshake
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   load             capture word and restart at slot 1
//   en               emitting allowed this cycle (sequencer in EMIT, no abort)
//   word             packed FIFO word
//   mv_ready         consumer accepts the presented move
//   mv_valid/mv_data presented move (data forced to 0 when not valid)
//   accept           a move is taken this cycle
//   word_consumed    slot 8 is finished this cycle
module lmg_unpack
    import lmg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [WORD_W-1:0] word,
    input  logic              mv_ready,
    output logic              mv_valid,
    output logic [MOVE_W-1:0] mv_data,
    output logic              accept,
    output logic              word_consumed
);
    localparam int PTR_W = $clog2(SLOTS);

    logic [WORD_W-1:0] buffer;
    logic [PTR_W-1:0]  ptr;
    logic [MOVE_W-1:0] cur;
    logic              advance;

    // Invalid slots advance unconditionally; valid ones wait for mv_ready,
    // which keeps data stable because buffer and ptr only move on advance.
    always_comb begin
        cur = slot(buffer, int'(ptr) + 1);
        mv_valid = en && !cur[INV_BIT];
        mv_data = mv_valid ? {cur[MOVE_W-1:FROM_HI+1], cur[FROM_HI:FROM_LO], cur[TO_HI:TO_LO]} : '0;
        accept = mv_valid && mv_ready;
        advance = en && (cur[INV_BIT] || mv_ready);
        word_consumed = advance && ptr == PTR_W'(SLOTS - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer <= '0;
            ptr <= '0;
        end else if (load) begin
            buffer <= word;
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr + 1'b1;
        end
    end
endmodule

// File: rtl/lmg_seq.sv
// lmg_seq: sequences one LMG run and streams its unpacked moves to the search engine
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   start, abort                  run request (IDLE only), return to IDLE (wins over start)
//   bstate_in/lcas_in/rcas_in/enp_in  position to evaluate, latched on start
//   lmg_reset, lmg_bstate, lmg_lcas, lmg_rcas, lmg_enp  drive to LMG
//   lmg_done, lmg_fifo_empty, lmg_fifo_out, lmg_rden   LMG status and move FIFO
//   mv_valid, mv_data, mv_ready   move stream, valid/ready handshake
//   busy, gen_done, mv_count, timeout_err  run status
module lmg_seq
    import lmg_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096,
    parameter int RD_LAT     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [BSTATE_W-1:0] bstate_in,
    input  logic                lcas_in,
    input  logic                rcas_in,
    input  logic [7:0]          enp_in,
    output logic                lmg_reset,
    output logic [BSTATE_W-1:0] lmg_bstate,
    output logic                lmg_lcas,
    output logic                lmg_rcas,
    output logic [7:0]          lmg_enp,
    input  logic                lmg_done,
    input  logic                lmg_fifo_empty,
    input  logic [WORD_W-1:0]   lmg_fifo_out,
    output logic                lmg_rden,
    output logic                mv_valid,
    output logic [MOVE_W-1:0]   mv_data,
    input  logic                mv_ready,
    output logic                busy,
    output logic                gen_done,
    output logic [7:0]          mv_count,
    output logic                timeout_err
);
    localparam int CW = $clog2(TIMEOUT + RST_CYCLES + RD_LAT + 1);

    lmgState       state, nextState;
    logic [CW-1:0] cnt;
    logic          startOk, timeoutHit, emitEn, loadWord, accept, wordConsumed;

    lmg_unpack unpack (
        .clk(clk),
        .reset(reset),
        .load(loadWord),
        .en(emitEn),
        .word(lmg_fifo_out),
        .mv_ready(mv_ready),
        .mv_valid(mv_valid),
        .mv_data(mv_data),
        .accept(accept),
        .word_consumed(wordConsumed)
    );

    // Outputs and qualifiers; kept apart from next-state so the unpack
    // handshake feeding back into the FSM is not a combinational loop.
    always_comb begin
        startOk = state == IDLE && start && !abort;
        timeoutHit = state == WAIT && !lmg_done && cnt == CW'(TIMEOUT - 1) && !abort;
        lmg_reset = state == IDLE || state == RST;
        lmg_rden = state == READ && !lmg_fifo_empty && !abort;
        busy = state != IDLE;
        gen_done = (state == FIN && !abort) || timeoutHit;
        emitEn = state == EMIT && !abort;
        loadWord = state == CAP && cnt == CW'(RD_LAT - 1) && !abort;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = start ? RST : IDLE;
            RST:     nextState = cnt == CW'(RST_CYCLES - 1) ? WAIT : RST;
            WAIT:    nextState = lmg_done ? READ : timeoutHit ? IDLE : WAIT;
            READ:    nextState = lmg_fifo_empty ? FIN : CAP;
            CAP:     nextState = cnt == CW'(RD_LAT - 1) ? EMIT : CAP;
            EMIT:    nextState = wordConsumed ? READ : EMIT;
            default: nextState = IDLE;
        endcase
        if (abort) nextState = IDLE;
    end

    // cnt restarts on every state change, so RST, WAIT and CAP each time
    // their own dwell from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            lmg_bstate <= '0;
            lmg_lcas <= 1'b0;
            lmg_rcas <= 1'b0;
            lmg_enp <= '0;
            mv_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= nextState;
            cnt <= nextState != state ? '0 : cnt + 1'b1;
            if (startOk) begin
                lmg_bstate <= bstate_in;
                lmg_lcas <= lcas_in;
                lmg_rcas <= rcas_in;
                lmg_enp <= enp_in;
                mv_count <= '0;
                timeout_err <= 1'b0;
            end
            if (accept && mv_count != 8'hFF) mv_count <= mv_count + 1'b1;
            if (timeoutHit) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lmg_seq.sv
// tb_lmg_seq: scoreboard bench for lmg_seq with a small behavioural LMG model
module tb_lmg_seq;
    import lmg_pkg::*;

    logic         clk = 0, reset = 0, start = 0, abort = 0;
    logic [255:0] bstate_in = '0;
    logic         lcas_in = 0, rcas_in = 0;
    logic [7:0]   enp_in = '0;
    logic         lmg_reset, lmg_lcas, lmg_rcas, lmg_rden;
    logic [255:0] lmg_bstate;
    logic [7:0]   lmg_enp;
    logic         lmg_done = 0, lmg_fifo_empty;
    logic [159:0] lmg_fifo_out = '0;
    logic         mv_valid, mv_ready = 0, busy, gen_done, timeout_err;
    logic [18:0]  mv_data;
    logic [7:0]   mv_count;

    int asserts = 0, fails = 0;
    logic [159:0] fifoMem [8];
    int nWords = 0, rd = 0, doneDelay = -1, dcnt = 0;
    logic [18:0] expQ [$];
    logic [18:0] sb [8];

    lmg_seq #(.RST_CYCLES(2), .TIMEOUT(64), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .bstate_in(bstate_in), .lcas_in(lcas_in), .rcas_in(rcas_in), .enp_in(enp_in),
        .lmg_reset(lmg_reset), .lmg_bstate(lmg_bstate), .lmg_lcas(lmg_lcas),
        .lmg_rcas(lmg_rcas), .lmg_enp(lmg_enp), .lmg_done(lmg_done),
        .lmg_fifo_empty(lmg_fifo_empty), .lmg_fifo_out(lmg_fifo_out), .lmg_rden(lmg_rden),
        .mv_valid(mv_valid), .mv_data(mv_data), .mv_ready(mv_ready), .busy(busy),
        .gen_done(gen_done), .mv_count(mv_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // LMG model: restarts while lmg_reset is high, raises done doneDelay
    // cycles after release, returns the FIFO word one cycle after rden.
    assign lmg_fifo_empty = rd >= nWords;
    always @(posedge clk) begin
        if (lmg_reset) begin
            rd <= 0;
            dcnt <= 0;
            lmg_done <= 0;
        end else begin
            dcnt <= dcnt + 1;
            if (doneDelay >= 0 && dcnt >= doneDelay) lmg_done <= 1;
            if (lmg_rden) begin
                lmg_fifo_out <= fifoMem[rd[2:0]];
                rd <= rd + 1;
            end
        end
    end

    function automatic logic [18:0] mv(input logic [5:0] f, input logic [5:0] t);
        return {7'b0, f, t};
    endfunction

    function automatic logic [18:0] bad();
        return {1'b1, 18'($urandom)};
    endfunction

    task automatic push_word();
        fifoMem[nWords] = {8'hA5, sb[0], sb[1], sb[2], sb[3], sb[4], sb[5], sb[6], sb[7]};
        nWords++;
        for (int k = 0; k < 8; k++) if (!sb[k][18]) expQ.push_back(sb[k]);
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        asserts++; if (lmg_reset !== 1'b1) begin fails++; $display("FAIL reset_lmg_reset: got %b expected 1", lmg_reset); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        asserts++; if (mv_valid !== 1'b0 || mv_data !== 19'd0) begin fails++; $display("FAIL reset_mv: got %b/%h expected 0/0", mv_valid, mv_data); end
        asserts++; if (gen_done !== 1'b0 || lmg_rden !== 1'b0) begin fails++; $display("FAIL reset_pulses: got %b/%b expected 0/0", gen_done, lmg_rden); end
        asserts++; if (mv_count !== 8'd0 || timeout_err !== 1'b0) begin fails++; $display("FAIL reset_status: got %0d/%b expected 0/0", mv_count, timeout_err); end
        asserts++; if (lmg_bstate !== 256'd0 || lmg_enp !== 8'd0) begin fails++; $display("FAIL reset_latch: got %h/%h expected 0/0", lmg_bstate, lmg_enp); end
        #2 reset = 1;
    endtask

    task automatic test_basic();
        int got = 0, gens = 0, rdens = 0, rstCyc = 0, tail = -1;
        logic [255:0] b;
        logic [18:0] e;
        b = {8{$urandom}};
        bstate_in = b; lcas_in = 1; rcas_in = 0; enp_in = 8'h24;
        nWords = 0; expQ.delete(); doneDelay = 10;
        sb = '{mv(6'o14, 6'o24), mv(6'o14, 6'o34), mv(6'o01, 6'o22), bad(), bad(), bad(), bad(), bad()};
        push_word();
        mv_ready = 1;
        kick();
        for (int i = 0; i < 300 && tail != 0; i++) begin
            if (tail > 0) tail--;
            if (busy && lmg_reset) rstCyc++;
            rdens += int'(lmg_rden);
            if (gen_done) begin gens++; if (tail < 0) tail = 4; end
            if (mv_valid && mv_ready) begin
                got++; asserts++;
                if (expQ.size() == 0) begin fails++; $display("FAIL basic_extra: got %h expected no move", mv_data); end
                else begin e = expQ.pop_front(); if (mv_data !== e) begin fails++; $display("FAIL basic_move: got %h expected %h", mv_data, e); end end
            end
            @(posedge clk); #1;
        end
        asserts++; if (got != 3) begin fails++; $display("FAIL basic_moves: got %0d expected 3", got); end
        asserts++; if (mv_count !== 8'd3) begin fails++; $display("FAIL basic_count: got %0d expected 3", mv_count); end
        asserts++; if (gens != 1) begin fails++; $display("FAIL basic_gen_done: got %0d pulses expected 1", gens); end
        asserts++; if (rdens != 1) begin fails++; $display("FAIL basic_rden: got %0d pulses expected 1", rdens); end
        asserts++; if (rstCyc != 2) begin fails++; $display("FAIL basic_rst_cycles: got %0d expected 2", rstCyc); end
        asserts++; if (lmg_bstate !== b) begin fails++; $display("FAIL basic_bstate: got %h expected %h", lmg_bstate, b); end
        asserts++; if ({lmg_lcas, lmg_rcas, lmg_enp} !== {1'b1, 1'b0, 8'h24}) begin fails++; $display("FAIL basic_flags: got %b%b %h expected 10 24", lmg_lcas, lmg_rcas, lmg_enp); end
        asserts++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("FAIL basic_idle: got busy %b err %b expected 0 0", busy, timeout_err); end
    endtask

    task automatic test_back_to_back();
        int got = 0, gens = 0, rdens = 0, tail = -1;
        logic pv = 0, pr = 0;
        logic [18:0] pd = '0, e;
        nWords = 0; expQ.delete(); doneDelay = 5;
        for (int k = 0; k < 8; k++) sb[k] = mv(6'($urandom), 6'($urandom));
        push_word();
        for (int k = 0; k < 8; k++) sb[k] = (k == 0 || k == 2 || k == 5 || k == 7) ? mv(6'($urandom), 6'($urandom)) : bad();
        push_word();
        kick();
        for (int i = 0; i < 400 && tail != 0; i++) begin
            if (tail > 0) tail--;
            mv_ready = i % 2 == 0;
            rdens += int'(lmg_rden);
            if (gen_done) begin gens++; if (tail < 0) tail = 4; end
            if (pv && !pr) begin
                asserts++;
                if (!mv_valid || mv_data !== pd) begin fails++; $display("FAIL b2b_stable: got %b/%h expected 1/%h", mv_valid, mv_data, pd); end
            end
            if (mv_valid && mv_ready) begin
                got++; asserts++;
                if (expQ.size() == 0) begin fails++; $display("FAIL b2b_extra: got %h expected no move", mv_data); end
                else begin e = expQ.pop_front(); if (mv_data !== e) begin fails++; $display("FAIL b2b_move: got %h expected %h", mv_data, e); end end
            end
            pv = mv_valid; pd = mv_data; pr = mv_ready;
            @(posedge clk); #1;
        end
        mv_ready = 1;
        asserts++; if (got != 12) begin fails++; $display("FAIL b2b_moves: got %0d expected 12", got); end
        asserts++; if (mv_count !== 8'd12) begin fails++; $display("FAIL b2b_count: got %0d expected 12", mv_count); end
        asserts++; if (rdens != 2) begin fails++; $display("FAIL b2b_rden: got %0d pulses expected 2", rdens); end
        asserts++; if (gens != 1) begin fails++; $display("FAIL b2b_gen_done: got %0d pulses expected 1", gens); end
    endtask

    task automatic test_empty();
        int got = 0, gens = 0, rdens = 0, doneAt = -1, genAt = -1;
        nWords = 0; expQ.delete(); doneDelay = 3; mv_ready = 1;
        kick();
        for (int i = 0; i < 100 && genAt < 0; i++) begin
            if (lmg_done && doneAt < 0) doneAt = i;
            if (gen_done) begin gens++; genAt = i; end
            got += int'(mv_valid);
            rdens += int'(lmg_rden);
            @(posedge clk); #1;
        end
        asserts++; if (gens != 1) begin fails++; $display("FAIL empty_gen_done: got %0d pulses expected 1", gens); end
        asserts++; if (doneAt < 0 || genAt <= doneAt || genAt - doneAt > 2) begin fails++; $display("FAIL empty_latency: got done %0d gen %0d expected gen within 2", doneAt, genAt); end
        asserts++; if (got != 0 || rdens != 0) begin fails++; $display("FAIL empty_activity: got %0d moves %0d rden expected 0 0", got, rdens); end
        asserts++; if (mv_count !== 8'd0) begin fails++; $display("FAIL empty_count: got %0d expected 0", mv_count); end
    endtask

    task automatic test_timeout();
        int waitCyc = 0, genWait = -1, gens = 0;
        nWords = 0; expQ.delete(); doneDelay = -1;
        kick();
        for (int i = 0; i < 200 && genWait < 0; i++) begin
            if (busy && !lmg_reset) waitCyc++;
            if (gen_done) begin gens++; genWait = waitCyc; end
            @(posedge clk); #1;
        end
        asserts++; if (genWait != 64) begin fails++; $display("FAIL timeout_cycle: got %0d expected 64", genWait); end
        asserts++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
        asserts++; if (busy !== 1'b0 || gens != 1) begin fails++; $display("FAIL timeout_idle: got busy %b gens %0d expected 0 1", busy, gens); end
        doneDelay = 2;
        kick();
        asserts++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_err_clear: got %b expected 0", timeout_err); end
        gens = 0;
        for (int i = 0; i < 100 && gens == 0; i++) begin
            if (gen_done) gens++;
            @(posedge clk); #1;
        end
        asserts++; if (gens != 1 || timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_rerun: got gens %0d err %b expected 1 0", gens, timeout_err); end
    endtask

    task automatic test_abort();
        int acc = 0, gens = 0;
        logic [18:0] e;
        nWords = 0; expQ.delete(); doneDelay = 4; mv_ready = 1;
        for (int k = 0; k < 8; k++) sb[k] = mv(6'($urandom), 6'($urandom));
        push_word();
        kick();
        for (int i = 0; i < 200; i++) begin
            if (acc == 2) begin mv_ready = 0; abort = 1; break; end
            if (mv_valid && mv_ready) begin
                acc++; asserts++;
                e = expQ.pop_front();
                if (mv_data !== e) begin fails++; $display("FAIL abort_move: got %h expected %h", mv_data, e); end
            end
            @(posedge clk); #1;
        end
        asserts++; if (acc != 2) begin fails++; $display("FAIL abort_reach: got %0d accepts expected 2", acc); end
        gens += int'(gen_done);
        @(posedge clk); #1 abort = 0;
        asserts++; if (busy !== 1'b0 || mv_valid !== 1'b0 || lmg_reset !== 1'b1) begin fails++; $display("FAIL abort_idle: got busy %b valid %b lmg_reset %b expected 0 0 1", busy, mv_valid, lmg_reset); end
        asserts++; if (mv_count !== 8'd2) begin fails++; $display("FAIL abort_count: got %0d expected 2", mv_count); end
        for (int i = 0; i < 5; i++) begin gens += int'(gen_done); @(posedge clk); #1; end
        asserts++; if (gens != 0) begin fails++; $display("FAIL abort_gen_done: got %0d pulses expected 0", gens); end
        mv_ready = 1;
        @(negedge clk); start = 1; abort = 1;
        @(posedge clk); #1 start = 0; abort = 0;
        asserts++; if (busy !== 1'b0 || mv_count !== 8'd2) begin fails++; $display("FAIL abort_wins: got busy %b count %0d expected 0 2", busy, mv_count); end
        expQ.delete();
    endtask

    task automatic test_async_reset();
        int got = 0, rdens = 0, tail = -1, seen = 0;
        logic [255:0] b;
        logic [18:0] e;
        b = {8{$urandom}};
        bstate_in = b;
        nWords = 0; expQ.delete(); doneDelay = 2; mv_ready = 0;
        for (int k = 0; k < 8; k++) sb[k] = mv(6'($urandom), 6'($urandom));
        push_word();
        kick();
        for (int i = 0; i < 100 && !seen; i++) begin
            if (mv_valid) seen = 1; else begin @(posedge clk); #1; end
        end
        asserts++; if (!seen) begin fails++; $display("FAIL areset_reach: got no mv_valid expected EMIT"); end
        bstate_in = ~b; start = 1;
        @(posedge clk); #1 start = 0;
        asserts++; if (lmg_bstate !== b || busy !== 1'b1) begin fails++; $display("FAIL busy_start: got busy %b bstate %h expected 1 %h", busy, lmg_bstate, b); end
        asserts++; if (mv_valid !== 1'b1 || mv_data !== expQ[0] || mv_count !== 8'd0) begin fails++; $display("FAIL busy_hold: got %b/%h/%0d expected 1/%h/0", mv_valid, mv_data, mv_count, expQ[0]); end
        #2 reset = 0;
        #1;
        asserts++; if (mv_valid !== 1'b0 || mv_data !== 19'd0 || busy !== 1'b0) begin fails++; $display("FAIL areset_mv: got %b/%h busy %b expected 0/0 0", mv_valid, mv_data, busy); end
        asserts++; if (lmg_reset !== 1'b1 || lmg_rden !== 1'b0 || gen_done !== 1'b0) begin fails++; $display("FAIL areset_ctl: got %b%b%b expected 100", lmg_reset, lmg_rden, gen_done); end
        asserts++; if (lmg_bstate !== 256'd0 || mv_count !== 8'd0 || timeout_err !== 1'b0) begin fails++; $display("FAIL areset_regs: got %h %0d %b expected 0 0 0", lmg_bstate, mv_count, timeout_err); end
        #3 reset = 1;
        nWords = 0; expQ.delete(); mv_ready = 1;
        sb = '{bad(), mv(6'o07, 6'o15), bad(), bad(), bad(), bad(), mv(6'o60, 6'o40), bad()};
        push_word();
        kick();
        for (int i = 0; i < 200 && tail != 0; i++) begin
            if (tail > 0) tail--;
            if (gen_done && tail < 0) tail = 3;
            rdens += int'(lmg_rden);
            if (mv_valid && mv_ready) begin
                got++; asserts++;
                if (expQ.size() == 0) begin fails++; $display("FAIL rerun_extra: got %h expected no move", mv_data); end
                else begin e = expQ.pop_front(); if (mv_data !== e) begin fails++; $display("FAIL rerun_move: got %h expected %h", mv_data, e); end end
            end
            @(posedge clk); #1;
        end
        asserts++; if (got != 2 || mv_count !== 8'd2 || rdens != 1) begin fails++; $display("FAIL rerun_summary: got %0d moves count %0d rden %0d expected 2 2 1", got, mv_count, rdens); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_empty();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
